video_pattern_gen: RTL and testbench
====================================

Name: video_pattern_gen

Overview:
- Source end of the hsync/vsync/de/24-bit RGB pixel stream consumed by the ISP pipeline (colour conversion, median, gauss).
- Generates raster timing from horizontal and vertical counters and fills active pixels with a selectable test pattern.
- Also outputs pixel coordinates.
- Used to drive the ISP chain in simulation and on-board bring-up without a camera.

Parameters:
- H_SYNC, 40, hsync width in clocks
- H_BP, 220, horizontal back porch
- H_ACTIVE, 1280, active pixels per line; must be a multiple of 8
- H_FP, 110, horizontal front porch
- V_SYNC, 5, vsync height in lines
- V_BP, 20, vertical back porch
- V_ACTIVE, 720, active lines
- V_FP, 5, vertical front porch
- SYNC_POL, 1, sync active level: 1 = active high, 0 = active low

Ports:
- clk, in, 1, pixel clock
- rst, in, 1, synchronous, active-high reset
- en, in, 1, run request; sampled at frame boundaries only
- mode, in, 2, pattern select: 0 solid, 1 colour bars, 2 grey ramp, 3 checker
- solid_rgb, in, 24, colour for mode 0, {R,G,B}
- hsync_o, out, 1, line sync
- vsync_o, out, 1, frame sync
- de_o, out, 1, active-pixel qualifier
- data_o, out, 24, pixel {R[23:16],G[15:8],B[7:0]}
- pixel_x, out, 11, active column; 0 when de_o=0
- pixel_y, out, 11, active row; 0 when de_o=0
- frame_start_o, out, 1, one-clock pulse on the first clock of each frame

Behaviour:
- Counter widths and totals:
  - Counters are 12 bits; H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP, V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
- Line and frame layout:
  - h_cnt runs 0..H_TOTAL-1 in the order sync, back porch, active, front porch.
  - v_cnt increments when h_cnt wraps, runs 0..V_TOTAL-1 in the same order, and wraps to 0.
- State machine, IDLE and RUN:
  - Reset enters IDLE with h_cnt = v_cnt = 0.
  - IDLE -> RUN when en=1. The first RUN clock has h_cnt=0, v_cnt=0.
  - RUN -> IDLE only at the frame boundary (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1) when en=0. Deasserting en mid-frame always completes the current frame.
  - In IDLE, counters hold at 0 and all outputs are idle.
- Mode and colour latching:
  - mode and solid_rgb are latched into internal registers at every frame start (IDLE->RUN, or wrap while staying in RUN).
  - Changes mid-frame take effect next frame.
- Output registration:
  - All outputs are registered, one clock after the counter state they describe.
  - hsync_o is active when h_cnt < H_SYNC; vsync_o is active when v_cnt < V_SYNC. Active level is SYNC_POL.
  - de_o = h in active region AND v in active region.
  - pixel_x = h_cnt-(H_SYNC+H_BP), pixel_y = v_cnt-(V_SYNC+V_BP).
- Patterns (data_o = 0 whenever de_o=0):
  - mode 0: latched solid_rgb.
  - mode 1: 8 vertical bars, each BAR_W=H_ACTIVE/8 wide, in order white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
    - The bar index comes from a bar counter that resets at the line's first active pixel and increments every BAR_W pixels. No divider.
  - mode 2: R=G=B=pixel_x[7:0], so the ramp repeats every 256 columns.
  - mode 3: pixel_x[5]^pixel_y[5] ? FFFFFF : 000000.
- frame_start_o: registered, asserted with the first clock of vsync_o active in each frame.
- Reset:
  - Values: hsync_o = vsync_o = ~SYNC_POL (inactive), de_o=0, data_o=0, pixel_x=pixel_y=0, frame_start_o=0, state=IDLE.
  - Reset mid-frame aborts immediately. The next frame starts from h_cnt=v_cnt=0 on the first clock after rst falls, if en=1.
- Boundary conditions:
  - The last active pixel of the last active line is followed by front porch with de_o=0.
  - v_cnt never increments except on h_cnt wrap.

Decomposition:
- Shared package video_pkg:
  - 1280x720 timing localparams (also used by the ISP bench).
  - Pattern mode encodings MODE_SOLID/BARS/RAMP/CHECK.
  - 8-entry bar colour constants.
- One natural sub-module, video_timing_ctr:
  - Owns the h/v counters and the IDLE/RUN FSM.
  - Emits raw sync/active/frame_start flags and coordinates.
- The top adds pattern muxing and the output registers.

Test Plan:
- Bench timing: tests use small timing H_SYNC=2, H_BP=2, H_ACTIVE=16, H_FP=2, V_SYNC=1, V_BP=1, V_ACTIVE=4, V_FP=1.
- Reset and idle: hold rst 5 clocks, then en=0 for 50 clocks -> hsync_o=vsync_o=0 (SYNC_POL=1), de_o=0, data_o=0, frame_start_o never pulses.
- Timing: en=1 for 3 frames with small timing -> period 22 clocks per line and 154 per frame; 16 de_o clocks per active line; 4 active lines per frame; pixel_x 0..15; pixel_y 0..3; frame_start_o pulses at cycles 1, 155, 309 after en rises.
- Colour bars: mode=1, small timing -> data_o is FFFFFF for x=0..1, FFFF00 for x=2..3, … 000000 for x=14..15, on every active line.
- Mid-frame mode change: change mode 2->3 at pixel_y=2 -> the rest of that frame stays ramp (data_o=0x010101 at x=1); the next frame is checker.
- Stop at frame end: drop en at pixel_y=1 -> the frame completes all 4 active lines and 154 clocks; then idle outputs with no further frame_start_o.
- Reset mid-frame: assert rst at pixel_y=2, x=7, for 1 clock with en=1 -> outputs go to reset values the next clock; frame_start_o re-pulses 1 clock after rst falls; pixel_y restarts at 0.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video definitions: 1280x720 raster timing, pattern mode
// encodings, colour-bar palette and the timing FSM state type.
package video_pkg;

    localparam int H_SYNC   = 40;
    localparam int H_BP     = 220;
    localparam int H_ACTIVE = 1280;
    localparam int H_FP     = 110;
    localparam int V_SYNC   = 5;
    localparam int V_BP     = 20;
    localparam int V_ACTIVE = 720;
    localparam int V_FP     = 5;
    localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [1:0] MODE_SOLID = 2'd0;
    localparam logic [1:0] MODE_BARS  = 2'd1;
    localparam logic [1:0] MODE_RAMP  = 2'd2;
    localparam logic [1:0] MODE_CHECK = 2'd3;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } vid_state_t;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/video_timing_ctr.sv
// Raster timing generator: horizontal/vertical counters plus the IDLE/RUN
// frame FSM. All outputs are combinational flags describing the current
// counter state; the top registers them.
//   clk, rst          : pixel clock, synchronous active-high reset
//   en                : run request, only acted on at frame boundaries
//   hs_raw, vs_raw    : inside sync region (active high, RUN only)
//   active            : inside active picture
//   frame_start       : first clock of a frame (h=0, v=0, RUN)
//   frame_load        : next clock begins a new frame (latch config now)
//   x, y              : active coordinates, 0 outside active picture
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | counters held at 0, no timing emitted, waiting for en
// ST_RUN  | counters advancing; leaves only at frame end with en=0
module video_timing_ctr
    import video_pkg::*;
#(
    parameter int H_SYNC   = video_pkg::H_SYNC,
    parameter int H_BP     = video_pkg::H_BP,
    parameter int H_ACTIVE = video_pkg::H_ACTIVE,
    parameter int H_FP     = video_pkg::H_FP,
    parameter int V_SYNC   = video_pkg::V_SYNC,
    parameter int V_BP     = video_pkg::V_BP,
    parameter int V_ACTIVE = video_pkg::V_ACTIVE,
    parameter int V_FP     = video_pkg::V_FP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        hs_raw,
    output logic        vs_raw,
    output logic        active,
    output logic        frame_start,
    output logic        frame_load,
    output logic [10:0] x,
    output logic [10:0] y
);

    localparam logic [11:0] H_SYNC_END  = 12'(H_SYNC);
    localparam logic [11:0] H_ACT_START = 12'(H_SYNC + H_BP);
    localparam logic [11:0] H_ACT_END   = 12'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [11:0] H_LAST      = 12'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [11:0] V_SYNC_END  = 12'(V_SYNC);
    localparam logic [11:0] V_ACT_START = 12'(V_SYNC + V_BP);
    localparam logic [11:0] V_ACT_END   = 12'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [11:0] V_LAST      = 12'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);

    vid_state_t  state_q, state_d;
    logic [11:0] h_cnt, h_d;
    logic [11:0] v_cnt, v_d;
    logic        h_end, v_end, run;

    assign h_end = (h_cnt == H_LAST);
    assign v_end = (v_cnt == V_LAST);
    assign run   = (state_q == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            state_q <= state_d;
            h_cnt   <= h_d;
            v_cnt   <= v_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        h_d        = h_cnt;
        v_d        = v_cnt;
        frame_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                h_d = '0;
                v_d = '0;
                if (en) begin
                    state_d    = ST_RUN;
                    frame_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (h_end) begin
                    h_d = '0;
                    v_d = v_end ? 12'd0 : v_cnt + 12'd1;
                end else begin
                    h_d = h_cnt + 12'd1;
                end
                if (h_end && v_end) begin
                    if (en) frame_load = 1'b1;
                    else    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                h_d     = '0;
                v_d     = '0;
            end
        endcase
    end

    always_comb begin
        hs_raw      = run && (h_cnt < H_SYNC_END);
        vs_raw      = run && (v_cnt < V_SYNC_END);
        active      = run && (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END)
                          && (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
        frame_start = run && (h_cnt == 12'd0) && (v_cnt == 12'd0);
        x           = active ? 11'(h_cnt - H_ACT_START) : 11'd0;
        y           = active ? 11'(v_cnt - V_ACT_START) : 11'd0;
    end

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern video source: raster timing plus pattern fill, all outputs
// registered one clock after the counter state they describe.
//   clk, rst          : pixel clock, synchronous active-high reset
//   en                : run request, sampled at frame boundaries
//   mode, solid_rgb   : pattern select / solid colour, latched per frame
//   hsync_o, vsync_o  : syncs at SYNC_POL level
//   de_o, data_o      : active qualifier and {R,G,B} pixel (0 when de_o=0)
//   pixel_x, pixel_y  : active coordinates (0 when de_o=0)
//   frame_start_o     : one-clock pulse on the first clock of each frame
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int   H_SYNC   = video_pkg::H_SYNC,
    parameter int   H_BP     = video_pkg::H_BP,
    parameter int   H_ACTIVE = video_pkg::H_ACTIVE,
    parameter int   H_FP     = video_pkg::H_FP,
    parameter int   V_SYNC   = video_pkg::V_SYNC,
    parameter int   V_BP     = video_pkg::V_BP,
    parameter int   V_ACTIVE = video_pkg::V_ACTIVE,
    parameter int   V_FP     = video_pkg::V_FP,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [23:0] solid_rgb,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o,
    output logic [23:0] data_o,
    output logic [10:0] pixel_x,
    output logic [10:0] pixel_y,
    output logic        frame_start_o
);

    localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);

    logic        hs_raw, vs_raw, active, frame_start, frame_load;
    logic [10:0] x, y;
    logic [1:0]  mode_q;
    logic [23:0] rgb_q;
    logic [2:0]  bar_idx;
    logic [11:0] bar_tmr;
    logic [23:0] pattern;

    video_timing_ctr #(
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .hs_raw      (hs_raw),
        .vs_raw      (vs_raw),
        .active      (active),
        .frame_start (frame_start),
        .frame_load  (frame_load),
        .x           (x),
        .y           (y)
    );

    // Config is captured on the edge that starts a frame so the whole
    // frame uses one consistent mode/colour.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_SOLID;
            rgb_q  <= '0;
        end else if (frame_load) begin
            mode_q <= mode;
            rgb_q  <= solid_rgb;
        end
    end

    // bar_idx/bar_tmr describe the current pixel. Both sit at their start
    // values outside the active picture, so each line's first active pixel
    // begins bar 0 with a full BAR_W count; the index then steps whenever
    // the down-counter hits zero.
    always_ff @(posedge clk) begin
        if (rst || !active) begin
            bar_idx <= '0;
            bar_tmr <= BAR_LAST;
        end else if (bar_tmr == 12'd0) begin
            bar_idx <= bar_idx + 3'd1;
            bar_tmr <= BAR_LAST;
        end else begin
            bar_tmr <= bar_tmr - 12'd1;
        end
    end

    always_comb begin
        pattern = '0;
        case (mode_q)
            MODE_SOLID: pattern = rgb_q;
            MODE_BARS:  pattern = bar_colour(bar_idx);
            MODE_RAMP:  pattern = {x[7:0], x[7:0], x[7:0]};
            MODE_CHECK: pattern = (x[5] ^ y[5]) ? 24'hFFFFFF : 24'h000000;
            default:    pattern = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_o       <= ~SYNC_POL;
            vsync_o       <= ~SYNC_POL;
            de_o          <= 1'b0;
            data_o        <= '0;
            pixel_x       <= '0;
            pixel_y       <= '0;
            frame_start_o <= 1'b0;
        end else begin
            hsync_o       <= hs_raw ? SYNC_POL : ~SYNC_POL;
            vsync_o       <= vs_raw ? SYNC_POL : ~SYNC_POL;
            de_o          <= active;
            data_o        <= active ? pattern : 24'h000000;
            pixel_x       <= x;
            pixel_y       <= y;
            frame_start_o <= frame_start;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen with small raster timing (22x7 clocks).
// Stimulus pushes expected active pixels into a queue; a monitor pops and
// compares on every de_o clock and also records frame_start/sync events.
module tb_video_pattern_gen;

    localparam int FRAME = 154;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [23:0] solid_rgb;
    logic        hsync_o, vsync_o, de_o, frame_start_o;
    logic [23:0] data_o;
    logic [10:0] pixel_x, pixel_y;

    video_pattern_gen #(
        .H_SYNC(2), .H_BP(2), .H_ACTIVE(16), .H_FP(2),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
        .SYNC_POL(1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .mode          (mode),
        .solid_rgb     (solid_rgb),
        .hsync_o       (hsync_o),
        .vsync_o       (vsync_o),
        .de_o          (de_o),
        .data_o        (data_o),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .frame_start_o (frame_start_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic [23:0] d;
    } pix_t;

    pix_t exp_q[$];
    int   fs_q[$];
    int   hs_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   en_cyc = 0;
    int   de_total = 0;
    int   vs_total = 0;
    logic hs_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] exp_pix(input int m, input int x, input int y,
                                            input logic [23:0] rgb);
        logic [7:0]  r;
        logic [10:0] xx, yy;
        r  = 8'(x);
        xx = 11'(x);
        yy = 11'(y);
        case (m)
            0: return rgb;
            1: case (x / 2)
                   0: return 24'hFFFFFF;
                   1: return 24'hFFFF00;
                   2: return 24'h00FFFF;
                   3: return 24'h00FF00;
                   4: return 24'hFF00FF;
                   5: return 24'hFF0000;
                   6: return 24'h0000FF;
                   default: return 24'h000000;
               endcase
            2: return {r, r, r};
            default: return (xx[5] ^ yy[5]) ? 24'hFFFFFF : 24'h000000;
        endcase
    endfunction

    task automatic push_rows(input int m, input logic [23:0] rgb,
                             input int y0, input int y1, input int last_x);
        pix_t p;
        for (int yy = y0; yy <= y1; yy++)
            for (int xx = 0; xx < 16; xx++)
                if (yy < y1 || xx <= last_x) begin
                    p.x = 11'(xx);
                    p.y = 11'(yy);
                    p.d = exp_pix(m, xx, yy, rgb);
                    exp_q.push_back(p);
                end
    endtask

    // Monitor: scoreboard pop on de_o, plus event logging.
    always @(negedge clk) begin
        pix_t e;
        if (de_o) begin
            de_total++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pixel: got x=%0d y=%0d data=%h, expected no pixel",
                         pixel_x, pixel_y, data_o);
            end else begin
                e = exp_q.pop_front();
                check("pixel_x", 64'(pixel_x), 64'(e.x));
                check("pixel_y", 64'(pixel_y), 64'(e.y));
                check("pixel_data", 64'(data_o), 64'(e.d));
            end
        end
        if (frame_start_o) fs_q.push_back(cyc - en_cyc);
        if (hsync_o && !hs_prev) hs_q.push_back(cyc);
        if (vsync_o) vs_total++;
        hs_prev = hsync_o;
    end

    task automatic idle_check(input string name, input int n);
        int bad;
        bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (de_o || hsync_o || vsync_o || frame_start_o || data_o != 24'h0 ||
                pixel_x != 11'd0 || pixel_y != 11'd0)
                bad++;
        end
        check(name, 64'(bad), 64'd0);
    endtask

    // Runs n frames, dropping en on pixel_y=1 of the last one.
    task automatic run_frames(input int n);
        int lim;
        fs_q.delete();
        hs_q.delete();
        de_total = 0;
        vs_total = 0;
        en_cyc   = cyc + 1;
        en       = 1'b1;
        lim = 0;
        while (fs_q.size() < n && lim < n * FRAME + 20) begin
            @(negedge clk);
            lim++;
        end
        lim = 0;
        while (!(de_o && pixel_y == 11'd1) && lim < 200) begin
            @(negedge clk);
            lim++;
        end
        en = 1'b0;
        while (cyc - en_cyc < n * FRAME + 4) @(negedge clk);
        check("frame_count", 64'(fs_q.size()), 64'(n));
        for (int k = 0; k < n; k++)
            if (k < fs_q.size()) check("frame_start_cycle", 64'(fs_q[k]), 64'(k * FRAME + 1));
        idle_check("idle_after_stop", 20);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int lim;
        rst       = 1'b1;
        en        = 1'b0;
        mode      = 2'd0;
        solid_rgb = 24'h0;
        repeat (5) @(negedge clk);
        check("reset_outputs",
              {hsync_o, vsync_o, de_o, frame_start_o, pixel_x, pixel_y, data_o}, 64'd0);
        rst = 1'b0;
        fs_q.delete();
        idle_check("idle_en0", 50);
        check("idle_no_frame_start", 64'(fs_q.size()), 64'd0);

        // Timing: 3 frames of solid colour.
        solid_rgb = 24'h123456;
        push_rows(0, 24'h123456, 0, 3, 15);
        push_rows(0, 24'h123456, 0, 3, 15);
        push_rows(0, 24'h123456, 0, 3, 15);
        run_frames(3);
        check("de_total", 64'(de_total), 64'd192);
        check("hsync_lines", 64'(hs_q.size()), 64'd21);
        if (hs_q.size() >= 2) check("line_period", 64'(hs_q[1] - hs_q[0]), 64'd22);
        check("vsync_clocks", 64'(vs_total), 64'd66);

        // Colour bars, 2 frames.
        mode = 2'd1;
        push_rows(1, 24'h0, 0, 3, 15);
        push_rows(1, 24'h0, 0, 3, 15);
        run_frames(2);

        // Mid-frame mode change: ramp frame stays ramp, next is checker.
        mode = 2'd2;
        push_rows(2, 24'h0, 0, 3, 15);
        push_rows(3, 24'h0, 0, 3, 15);
        fork
            run_frames(2);
            begin
                lim = 0;
                while (!(de_o && pixel_y == 11'd2) && lim < 200) begin
                    @(negedge clk);
                    lim++;
                end
                mode = 2'd3;
            end
        join

        // Reset mid-frame at pixel_y=2, x=7.
        mode      = 2'd0;
        solid_rgb = 24'hA5A5A5;
        push_rows(0, 24'hA5A5A5, 0, 2, 7);
        fs_q.delete();
        en_cyc = cyc + 1;
        en     = 1'b1;
        lim = 0;
        while (!(de_o && pixel_y == 11'd2 && pixel_x == 11'd7) && lim < 300) begin
            @(negedge clk);
            lim++;
        end
        rst = 1'b1;
        @(negedge clk);
        check("midframe_reset_outputs",
              {hsync_o, vsync_o, de_o, frame_start_o, pixel_x, pixel_y, data_o}, 64'd0);
        check("partial_frame_drained", 64'(exp_q.size()), 64'd0);
        rst = 1'b0;
        fs_q.delete();
        en_cyc = cyc + 1;
        push_rows(0, 24'hA5A5A5, 0, 3, 15);
        lim = 0;
        while (fs_q.size() < 1 && lim < 20) begin
            @(negedge clk);
            lim++;
        end
        check("restart_frame_count", 64'(fs_q.size()), 64'd1);
        if (fs_q.size() > 0) check("restart_frame_start", 64'(fs_q[0]), 64'd1);
        lim = 0;
        while (!(de_o && pixel_y == 11'd1) && lim < 200) begin
            @(negedge clk);
            lim++;
        end
        en = 1'b0;
        while (cyc - en_cyc < FRAME + 4) @(negedge clk);
        check("restart_single_frame", 64'(fs_q.size()), 64'd1);
        check("restart_queue_drained", 64'(exp_q.size()), 64'd0);
        idle_check("idle_after_restart", 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
